cond_unit_it: RTL and testbench
===============================

# cond_unit_it

Parametrised conditional-execution unit for the pipelined ARM core's Execute stage. It owns the architectural NZCV flag register and evaluates the 4-bit condition code against it. It writes ALU flags back in configurable write groups. It adds an If-Then (IT) sequencer that supplies conditions to up to `IT_DEPTH` following instructions, and it honours pipeline stall and flush.

## Interface
- `FLAGS_W`, 4: flag register width, ordered {N,Z,C,V} in the top four bits.
- `FW_GROUPS`, 2: number of independently enabled flag write groups. Group g covers bits `[(g+1)*FLAGS_W/FW_GROUPS-1 : g*FLAGS_W/FW_GROUPS]`. `FLAGS_W` must be divisible by `FW_GROUPS`.
- `IT_DEPTH`, 4: maximum instructions covered by one IT block.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `en`  in  1  Execute stage advances this cycle (inverse of StallE)
- `flush`  in  1  squash the instruction in Execute
- `valid`  in  1  Execute holds a real instruction
- `Cond`  in  4  instruction condition field
- `FlagsWrite`  in  FW_GROUPS  per-group flag write request
- `ALUFlags`  in  FLAGS_W  flags produced by the ALU this cycle
- `it_start`  in  1  instruction in Execute is an IT instruction
- `it_firstcond`  in  4  IT base condition
- `it_len`  in  $clog2(IT_DEPTH+1)  number of covered instructions, 1..IT_DEPTH
- `it_then`  in  IT_DEPTH  bit i=1: slot i uses firstcond; bit i=0: slot i uses firstcond^4'b0001; bit 0 is ignored (always "then")
- `CondEx`  out  1  instruction executes (combinational)
- `Flags`  out  FLAGS_W  architectural flags (registered)
- `FlagsNext`  out  FLAGS_W  value Flags takes at the next edge if `en`
- `it_active`  out  1  IT block in progress
- `it_left`  out  $clog2(IT_DEPTH+1)  slots remaining

## Operation
- The effective condition `ec` is the current IT slot condition when `it_active`, else `Cond`.
- Evaluation uses the ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Code 4'b1111 evaluates to 0; it never yields X.
- `CondEx = valid & ~flush & eval(ec, Flags)`.
- An IT instruction itself (`it_start` with `it_active`=0) has `CondEx`=1 and never writes flags.
- Flag writes: for each group g, `FlagsNext[group g] = (FlagsWrite[g] & CondEx) ? ALUFlags[group g] : Flags[group g]`.
- `Flags <= FlagsNext` only when `en`.
- IT state machine:
  - IDLE → ACTIVE when `en & valid & ~flush & it_start`. On this transition, load `it_left=it_len`, slot index 0, firstcond and the then mask. An `it_len` of 0 is treated as 1.
  - ACTIVE: each `en & valid & ~flush` cycle consumes one slot, whether or not its condition passed. Then `it_left` decrements and the slot index increments. When `it_left` reaches 0 the state returns to IDLE.
  - `it_start` while ACTIVE is not a new IT. It is consumed as an ordinary conditional slot.
  - Cycles with `valid`=0 (bubbles) do not consume slots.
- `flush` with `en`: IT state → IDLE and `it_left` → 0. Flags are unchanged because `CondEx` is 0.

## Timing
- Reset values: `Flags`=0, IDLE, `it_left`=0, `it_active`=0. `CondEx` and `FlagsNext` follow combinationally from the reset state.
- `CondEx` and `FlagsNext` have zero latency from inputs.
- `Flags` has 1-cycle latency: an instruction in Execute at cycle t sees flags written by the instruction at t-1.
- `en`=0: Flags and IT state hold. `CondEx` still reflects current inputs.
- `flush` with `en`=0: no state change; flush takes effect on the first cycle with `en`.
- The last IT slot and a new IT on the following instruction may occur back to back with no gap.
- Reset asserted mid-IT returns to IDLE at the next edge; reset has priority over all other inputs.

## Structure
- Package `cond_pkg`: cond-code localparams (COND_EQ..COND_NV), the IT state enum {IT_IDLE, IT_ACTIVE}, and flag bit indices N/Z/C/V.
- Sub-module `cond_eval`: a purely combinational evaluator of (cond, NZCV) → pass. It is also reused by the branch unit.
- The top level holds the flag register, the group-write muxing and the IT FSM.

## Test plan
- Reset, then Cond=EQ with Flags=0 → CondEx=0. Write ALUFlags=4'b0100 with FlagsWrite=2'b11 → next cycle Flags=4'b0100 and EQ gives CondEx=1.
- FlagsWrite=2'b10 with ALUFlags=4'b1111 and Flags=0 → Flags=4'b1100 (C and V untouched).
- Cond=4'b1111 with any flags → CondEx=0 and no flag write.
- IT with firstcond=EQ, it_len=3, it_then=4'b0101 (slots 1,2: else, then), Z=1 → CondEx for slots 0,1,2 = 1,0,1. A bubble between slots leaves it_left unchanged. it_active drops after slot 2.
- en=0 for 3 cycles mid-IT with FlagsWrite asserted → Flags and it_left stay frozen.
- flush on IT slot 1 → CondEx=0 and it_active=0 next cycle. A separate run with reset mid-IT → it_left=0 and Flags=0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared condition-code encodings, IT sequencer state and NZCV bit positions
// for the Execute-stage conditional logic and the branch unit.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   typedef enum logic [0:0] {
      IT_IDLE   = 1'b0,
      IT_ACTIVE = 1'b1
   } it_state_t;

   // Bit positions within the 4-bit NZCV nibble.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: (cond, NZCV) -> pass, zero latency.
// No flow control; code 4'b1111 always fails so the output is never X.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit_it.sv
// Execute-stage conditional unit: NZCV register, grouped flag writes, IT sequencer.
// CondEx/FlagsNext are combinational; Flags and IT state update one edge later, held while en=0.
module cond_unit_it
   import cond_pkg::*;
#(
   parameter int FLAGS_W   = 4,
   parameter int FW_GROUPS = 2,
   parameter int IT_DEPTH  = 4,
   localparam int LW = $clog2(IT_DEPTH + 1),
   localparam int IW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 flush,
   input  logic                 valid,
   input  logic [3:0]           Cond,
   input  logic [FW_GROUPS-1:0] FlagsWrite,
   input  logic [FLAGS_W-1:0]   ALUFlags,
   input  logic                 it_start,
   input  logic [3:0]           it_firstcond,
   input  logic [LW-1:0]        it_len,
   input  logic [IT_DEPTH-1:0]  it_then,
   output logic                 CondEx,
   output logic [FLAGS_W-1:0]   Flags,
   output logic [FLAGS_W-1:0]   FlagsNext,
   output logic                 it_active,
   output logic [LW-1:0]        it_left
);

   localparam int GW = FLAGS_W / FW_GROUPS;

   it_state_t           it_state;
   logic [IW-1:0]       slot_idx;
   logic [3:0]          firstcond_q;
   logic [IT_DEPTH-1:0] then_q;

   logic [3:0]          slot_cond;
   logic [3:0]          ec;
   logic                is_it_instr;
   logic                eval_pass;
   logic                live;
   logic [LW-1:0]       len_eff;

   assign it_active   = (it_state == IT_ACTIVE);
   assign is_it_instr = it_start & ~it_active;
   assign live        = valid & ~flush;

   // Slot 0 always takes the base condition; later slots flip bit 0 on "else".
   assign slot_cond = (slot_idx == '0 || then_q[slot_idx]) ? firstcond_q
                                                           : (firstcond_q ^ 4'b0001);
   assign ec = it_active ? slot_cond : Cond;

   cond_eval u_eval (
      .cond (ec),
      .nzcv (Flags[FLAGS_W-1 -: 4]),
      .pass (eval_pass)
   );

   assign CondEx = live & (is_it_instr | eval_pass);

   for (genvar g = 0; g < FW_GROUPS; g++) begin : g_fw
      assign FlagsNext[g*GW +: GW] = (FlagsWrite[g] & CondEx & ~is_it_instr)
                                     ? ALUFlags[g*GW +: GW] : Flags[g*GW +: GW];
   end

   // A zero length still covers one instruction; oversized lengths saturate.
   always_comb begin
      len_eff = it_len;
      if (it_len == '0)
         len_eff = LW'(1);
      else if (it_len > LW'(IT_DEPTH))
         len_eff = LW'(IT_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Flags <= '0;
      end else if (en) begin
         Flags <= FlagsNext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         it_state    <= IT_IDLE;
         it_left     <= '0;
         slot_idx    <= '0;
         firstcond_q <= '0;
         then_q      <= '0;
      end else if (en) begin
         if (flush) begin
            it_state <= IT_IDLE;
            it_left  <= '0;
            slot_idx <= '0;
         end else if (valid) begin
            if (is_it_instr) begin
               it_state    <= IT_ACTIVE;
               it_left     <= len_eff;
               slot_idx    <= '0;
               firstcond_q <= it_firstcond;
               then_q      <= it_then;
            end else if (it_active) begin
               it_left  <= it_left - LW'(1);
               slot_idx <= slot_idx + IW'(1);
               if (it_left == LW'(1)) begin
                  it_state <= IT_IDLE;
                  slot_idx <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cond_unit_it.sv
// Directed bench for cond_unit_it: condition table vectors plus IT, stall, flush and reset sequences.
module tb_cond_unit_it;

   logic       clk = 1'b0;
   logic       reset, en, flush, valid;
   logic [3:0] Cond;
   logic [1:0] FlagsWrite;
   logic [3:0] ALUFlags;
   logic       it_start;
   logic [3:0] it_firstcond;
   logic [2:0] it_len;
   logic [3:0] it_then;
   logic       CondEx;
   logic [3:0] Flags, FlagsNext;
   logic       it_active;
   logic [2:0] it_left;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   cond_unit_it #(.FLAGS_W(4), .FW_GROUPS(2), .IT_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid(valid),
      .Cond(Cond), .FlagsWrite(FlagsWrite), .ALUFlags(ALUFlags),
      .it_start(it_start), .it_firstcond(it_firstcond), .it_len(it_len),
      .it_then(it_then), .CondEx(CondEx), .Flags(Flags), .FlagsNext(FlagsNext),
      .it_active(it_active), .it_left(it_left)
   );

   typedef struct {
      logic [3:0] nzcv;
      logic [3:0] cond;
      logic       exp;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive at posedge+1, so checks taken #1 later are away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic defaults();
      en = 1'b1; flush = 1'b0; valid = 1'b1; Cond = 4'he;
      FlagsWrite = 2'b00; ALUFlags = 4'h0; it_start = 1'b0;
      it_firstcond = 4'h0; it_len = 3'd0; it_then = 4'h0;
   endtask

   task automatic load_flags(input logic [3:0] f);
      defaults();
      ALUFlags = f; FlagsWrite = 2'b11; Cond = 4'he;
      tick();
      FlagsWrite = 2'b00;
   endtask

   task automatic start_it(input logic [3:0] fc, input logic [2:0] len, input logic [3:0] th);
      defaults();
      it_start = 1'b1; it_firstcond = fc; it_len = len; it_then = th;
      tick();
      it_start = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{4'b0000, 4'h0, 1'b0};
      vecs[1]  = '{4'b0100, 4'h0, 1'b1};
      vecs[2]  = '{4'b0100, 4'h1, 1'b0};
      vecs[3]  = '{4'b0010, 4'h2, 1'b1};
      vecs[4]  = '{4'b0000, 4'h3, 1'b1};
      vecs[5]  = '{4'b1000, 4'h4, 1'b1};
      vecs[6]  = '{4'b1000, 4'h5, 1'b0};
      vecs[7]  = '{4'b0001, 4'h6, 1'b1};
      vecs[8]  = '{4'b0001, 4'h7, 1'b0};
      vecs[9]  = '{4'b0010, 4'h8, 1'b1};
      vecs[10] = '{4'b0110, 4'h8, 1'b0};
      vecs[11] = '{4'b0110, 4'h9, 1'b1};
      vecs[12] = '{4'b1001, 4'ha, 1'b1};
      vecs[13] = '{4'b1000, 4'hb, 1'b1};
      vecs[14] = '{4'b1001, 4'hc, 1'b1};
      vecs[15] = '{4'b1101, 4'hc, 1'b0};
      vecs[16] = '{4'b0100, 4'hd, 1'b1};
      vecs[17] = '{4'b0001, 4'hd, 1'b1};
      vecs[18] = '{4'b0000, 4'he, 1'b1};
      vecs[19] = '{4'b1111, 4'hf, 1'b0};

      defaults();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      settle();
      chk("reset_flags", {4'h0, Flags}, 8'h00);
      chk("reset_active", {7'h0, it_active}, 8'h00);
      chk("reset_left", {5'h0, it_left}, 8'h00);

      Cond = 4'h0;
      settle();
      chk("eq_on_zero", {7'h0, CondEx}, 8'h00);
      chk("flagsnext_idle", {4'h0, FlagsNext}, 8'h00);

      ALUFlags = 4'b0100; FlagsWrite = 2'b11; Cond = 4'he;
      settle();
      chk("al_condex", {7'h0, CondEx}, 8'h01);
      chk("flagsnext_write", {4'h0, FlagsNext}, 8'h04);
      chk("flags_not_yet", {4'h0, Flags}, 8'h00);
      tick();
      FlagsWrite = 2'b00; Cond = 4'h0;
      settle();
      chk("flags_after_write", {4'h0, Flags}, 8'h04);
      chk("eq_after_write", {7'h0, CondEx}, 8'h01);

      load_flags(4'b0000);
      FlagsWrite = 2'b10; ALUFlags = 4'b1111; Cond = 4'he;
      tick();
      FlagsWrite = 2'b00;
      settle();
      chk("group_hi_write", {4'h0, Flags}, 8'h0c);

      FlagsWrite = 2'b11; ALUFlags = 4'b0011; Cond = 4'hf;
      settle();
      chk("nv_condex", {7'h0, CondEx}, 8'h00);
      chk("nv_flagsnext", {4'h0, FlagsNext}, 8'h0c);
      tick();
      chk("nv_no_write", {4'h0, Flags}, 8'h0c);

      for (int i = 0; i < 20; i++) begin
         load_flags(vecs[i].nzcv);
         Cond = vecs[i].cond;
         settle();
         chk($sformatf("vec%0d_flags", i), {4'h0, Flags}, {4'h0, vecs[i].nzcv});
         chk($sformatf("vec%0d_condex", i), {7'h0, CondEx}, {7'h0, vecs[i].exp});
      end

      valid = 1'b0; Cond = 4'he;
      settle();
      chk("bubble_condex", {7'h0, CondEx}, 8'h00);
      valid = 1'b1; flush = 1'b1;
      settle();
      chk("flush_condex", {7'h0, CondEx}, 8'h00);
      flush = 1'b0;

      // IT EQ, 3 slots: then, else, then; Z set.
      load_flags(4'b0100);
      it_start = 1'b1; it_firstcond = 4'h0; it_len = 3'd3; it_then = 4'b0101;
      FlagsWrite = 2'b11; ALUFlags = 4'b1111; Cond = 4'hf;
      settle();
      chk("it_instr_condex", {7'h0, CondEx}, 8'h01);
      chk("it_instr_nowrite", {4'h0, FlagsNext}, 8'h04);
      tick();
      it_start = 1'b0; FlagsWrite = 2'b00; Cond = 4'he;
      settle();
      chk("it_active_set", {7'h0, it_active}, 8'h01);
      chk("it_left_3", {5'h0, it_left}, 8'h03);
      chk("it_slot0", {7'h0, CondEx}, 8'h01);
      tick();
      chk("it_left_2", {5'h0, it_left}, 8'h02);
      valid = 1'b0;
      tick();
      chk("bubble_hold_left", {5'h0, it_left}, 8'h02);
      valid = 1'b1;
      settle();
      chk("it_slot1_else", {7'h0, CondEx}, 8'h00);
      tick();
      chk("it_left_1", {5'h0, it_left}, 8'h01);
      it_start = 1'b1; it_firstcond = 4'h1; it_len = 3'd2; it_then = 4'b0000;
      settle();
      chk("it_slot2_then", {7'h0, CondEx}, 8'h01);
      tick();
      it_start = 1'b0;
      settle();
      chk("it_done_left", {5'h0, it_left}, 8'h00);
      chk("it_done_active", {7'h0, it_active}, 8'h00);

      // Back-to-back IT, then a 3-cycle stall with writes pending.
      start_it(4'h0, 3'd2, 4'b0011);
      settle();
      chk("b2b_active", {7'h0, it_active}, 8'h01);
      chk("b2b_left", {5'h0, it_left}, 8'h02);
      tick();
      en = 1'b0; FlagsWrite = 2'b11; ALUFlags = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("stall%0d_condex", k), {7'h0, CondEx}, 8'h01);
         tick();
         chk($sformatf("stall%0d_flags", k), {4'h0, Flags}, 8'h04);
         chk($sformatf("stall%0d_left", k), {5'h0, it_left}, 8'h01);
      end
      en = 1'b1; FlagsWrite = 2'b00;
      settle();
      chk("post_stall_slot1", {7'h0, CondEx}, 8'h01);
      tick();
      chk("post_stall_idle", {7'h0, it_active}, 8'h00);

      // Flush on slot 1; flush held while stalled must wait for en.
      start_it(4'h0, 3'd3, 4'b1111);
      tick();
      en = 1'b0; flush = 1'b1;
      tick();
      chk("flush_stalled_hold", {7'h0, it_active}, 8'h01);
      en = 1'b1; FlagsWrite = 2'b11; ALUFlags = 4'b0000;
      settle();
      chk("flush_slot_condex", {7'h0, CondEx}, 8'h00);
      chk("flush_flagsnext", {4'h0, FlagsNext}, 8'h04);
      tick();
      defaults();
      settle();
      chk("flush_active", {7'h0, it_active}, 8'h00);
      chk("flush_left", {5'h0, it_left}, 8'h00);
      chk("flush_flags", {4'h0, Flags}, 8'h04);

      start_it(4'h0, 3'd0, 4'b0000);
      settle();
      chk("len0_as_1", {5'h0, it_left}, 8'h01);
      tick();
      chk("len0_done", {7'h0, it_active}, 8'h00);

      // Reset in the middle of an IT block.
      start_it(4'h0, 3'd3, 4'b1111);
      tick();
      reset = 1'b1; it_start = 1'b1; FlagsWrite = 2'b11; ALUFlags = 4'hf;
      tick();
      reset = 1'b0;
      defaults();
      settle();
      chk("rst_mid_left", {5'h0, it_left}, 8'h00);
      chk("rst_mid_active", {7'h0, it_active}, 8'h00);
      chk("rst_mid_flags", {4'h0, Flags}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
